// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC conversion controller.
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    DONE   = 2'd3
  } conv_state_t;

  localparam logic [1:0] ADC_NONE = 2'd0;
  localparam logic [1:0] ADC_PWM  = 2'd1;
  localparam logic [1:0] ADC_R2R  = 2'd2;
  localparam logic [1:0] ADC_RSVD = 2'd3;

endpackage

// File: rtl/comp_synchronizer.sv
// Two-flop synchronizer that brings the asynchronous comparator output into the clk domain.
module comp_synchronizer (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;

  // Two back-to-back flops; the first may go metastable, the second resolves it.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta_q   <= async_in;
      sync_out <= meta_q;
    end
  end

endmodule

// File: rtl/adc_conversion_ctrl.sv
// ADC conversion controller: drives the shared DAC code, enables the selected DAC
// (PWM or R2R) and runs a ramp or SAR conversion against the synchronized comparator.
// Optional build macro ADC_AVG_EN: average 2^AVG_LOG2 consecutive results per output.
//
// state  | meaning
// IDLE   | no conversion; dac_code = 0; starts when adc_sel is PWM or R2R
// SETTLE | DAC settling on the current trial code (SETTLE_CYCLES cycles)
// DECIDE | one-cycle comparator decision, choose next trial or finish
// DONE   | result presented with sample_valid, back to IDLE
import adc_pkg::*;

module adc_conversion_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            adc_sel,
  input  logic                  successive_approx,
  input  logic                  comp_in,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic                  pwm_dac_en,
  output logic                  r2r_dac_en,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_MSB     = IDX_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] CODE_ONE    = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] CODE_MAX    = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0] CODE_MSB    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  conv_state_t           state_q;
  logic [1:0]            cur_sel_q;
  logic                  cur_sar_q;
  logic [CNT_W-1:0]      settle_cnt_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic                  comp_s;

  logic                  sel_active;
  logic                  mode_changed;
  logic                  abort;
  logic [DATA_WIDTH-1:0] trial_bit;
  logic [DATA_WIDTH-1:0] sar_kept;
  logic [DATA_WIDTH-1:0] sar_next;
  logic [DATA_WIDTH-1:0] ramp_result;
  logic                  decide_done;
  logic [DATA_WIDTH-1:0] conv_result;
  logic                  result_load;

  comp_synchronizer u_comp_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (comp_in),
    .sync_out (comp_s)
  );

  // Mode decode, abort detection and per-algorithm next-trial / result computation.
  always_comb begin
    sel_active   = (adc_sel != ADC_NONE) && (adc_sel != ADC_RSVD);
    mode_changed = (adc_sel != cur_sel_q) || (successive_approx != cur_sar_q);
    busy         = (state_q == SETTLE) || (state_q == DECIDE);
    abort        = busy && mode_changed;
    pwm_dac_en   = busy && (cur_sel_q == ADC_PWM);
    r2r_dac_en   = busy && (cur_sel_q == ADC_R2R);

    trial_bit    = CODE_ONE << bit_idx_q;
    sar_kept     = comp_s ? dac_code : (dac_code & ~trial_bit);
    sar_next     = sar_kept | (trial_bit >> 1);
    // A ramp stopped by a rejection reports the last accepted code; code 0 and
    // an accepted full-scale code report themselves.
    ramp_result  = (comp_s || (dac_code == '0)) ? dac_code : (dac_code - CODE_ONE);

    decide_done  = cur_sar_q ? (bit_idx_q == '0) : !(comp_s && (dac_code != CODE_MAX));
    conv_result  = cur_sar_q ? sar_kept : ramp_result;
    result_load  = (state_q == DECIDE) && !abort && decide_done;
  end

  // Conversion FSM with the settle down-counter, SAR bit index and DAC code.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_sel_q    <= ADC_NONE;
      cur_sar_q    <= 1'b0;
      settle_cnt_q <= '0;
      bit_idx_q    <= '0;
      dac_code     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          dac_code <= '0;
          if (sel_active) begin
            cur_sel_q    <= adc_sel;
            cur_sar_q    <= successive_approx;
            dac_code     <= successive_approx ? CODE_MSB : '0;
            bit_idx_q    <= IDX_MSB;
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= SETTLE;
          end
        end
        SETTLE: begin
          if (abort) begin
            dac_code <= '0;
            state_q  <= IDLE;
          end else if (settle_cnt_q == '0) begin
            state_q <= DECIDE;
          end else begin
            settle_cnt_q <= settle_cnt_q - CNT_W'(1);
          end
        end
        DECIDE: begin
          if (abort) begin
            dac_code <= '0;
            state_q  <= IDLE;
          end else if (decide_done) begin
            dac_code <= conv_result;
            state_q  <= DONE;
          end else begin
            dac_code     <= cur_sar_q ? sar_next : (dac_code + CODE_ONE);
            bit_idx_q    <= bit_idx_q - IDX_W'(1);
            settle_cnt_q <= SETTLE_LOAD;
            state_q      <= SETTLE;
          end
        end
        default: begin
          dac_code <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

`ifdef ADC_AVG_EN
  localparam int ACC_W = DATA_WIDTH + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [AVG_LOG2-1:0] grp_q;
  logic [ACC_W-1:0]    acc_sum;
  logic                group_clear;

  // A group restarts whenever a conversion is aborted or a new one starts in a different mode.
  always_comb begin
    acc_sum     = acc_q + ACC_W'(conv_result);
    group_clear = abort || ((state_q == IDLE) && sel_active && mode_changed);
  end

  // Accumulate results; publish the truncated mean once per full group.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      grp_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (group_clear) begin
        acc_q <= '0;
        grp_q <= '0;
      end else if (result_load) begin
        if (grp_q == '1) begin
          sample_out   <= acc_sum[ACC_W-1:AVG_LOG2];
          sample_valid <= 1'b1;
          acc_q        <= '0;
          grp_q        <= '0;
        end else begin
          acc_q <= acc_sum;
          grp_q <= grp_q + AVG_LOG2'(1);
        end
      end
    end
  end
`else
  logic unused_avg_cfg;
  assign unused_avg_cfg = |AVG_LOG2;

  // Every finished conversion goes straight to the output with a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= result_load;
      if (result_load) begin
        sample_out <= conv_result;
      end
    end
  end
`endif

endmodule

// File: doc/adc_conversion_ctrl.md
Name: adc_conversion_ctrl

Overview:
- Downstream consumer of the menu FSM's ADC selection outputs: ADC_sel[1:0] and successive_approx.
- Drives the shared DAC code and the enable for the selected DAC: PWM or R2R.
- Samples the external analog comparator and performs either a linear ramp conversion or a successive-approximation (SAR) conversion.
- Presents each finished result with a one-cycle valid strobe to the scaling/display path.

Parameters:
- DATA_WIDTH, 8, width of DAC code and conversion result.
- SETTLE_CYCLES, 4, cycles the DAC settles before each comparator decision; must be >= 3.
- AVG_LOG2, 2, log2 of the number of conversions averaged; used only with ADC_AVG_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- adc_sel  in  2  0 = no ADC, 1 = PWM DAC ADC, 2 = R2R DAC ADC, 3 = treated as 0.
- successive_approx  in  1  1 = SAR algorithm, 0 = ramp algorithm.
- comp_in  in  1  asynchronous comparator output; 1 when Vin >= Vdac.
- dac_code  out  DATA_WIDTH  current trial code to both DACs.
- pwm_dac_en  out  1  enable for the PWM DAC.
- r2r_dac_en  out  1  enable for the R2R DAC.
- sample_out  out  DATA_WIDTH  last completed result; held between conversions.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset values: all outputs 0; state IDLE; synchronizer flops 0.
- comp_in passes through a 2-flop synchronizer (comp_s) before use.
- Mode capture: adc_sel and successive_approx are latched on IDLE exit into cur_sel and cur_sar.
  - pwm_dac_en = (cur_sel==1) && busy.
  - r2r_dac_en = (cur_sel==2) && busy.
- States:
  - IDLE: if adc_sel is 1 or 2, initialise the first trial and go to SETTLE next cycle. Otherwise stay; dac_code = 0.
  - SETTLE: settle counter runs SETTLE_CYCLES cycles, then go to DECIDE.
  - DECIDE: sample comp_s in a single cycle and update per algorithm; next state is SETTLE (more trials) or DONE.
  - DONE: load sample_out, assert sample_valid for 1 cycle, return to IDLE. busy = 0 in DONE and IDLE.
- SAR:
  - Initial dac_code = 1<<(DATA_WIDTH-1); bit index = MSB.
  - In DECIDE: if comp_s==0, clear the trial bit. If the index is above 0, set the next lower bit and decrement the index; otherwise go to DONE.
  - Result = final dac_code. Exactly DATA_WIDTH trials.
- Ramp:
  - Initial dac_code = 0.
  - In DECIDE: if comp_s==1 and dac_code != max, increment and continue. Otherwise go to DONE.
  - Result:
    - 0 if the stop was at code 0.
    - max if the stop was at max with comp_s==1.
    - otherwise dac_code-1.
- Latency: each trial takes SETTLE_CYCLES+1 cycles. SAR: sample_valid fires DATA_WIDTH*(SETTLE_CYCLES+1)+1 cycles after IDLE exit.
- Abort: if adc_sel or successive_approx differs from the latched value during SETTLE or DECIDE, go to IDLE next cycle.
  - No sample_valid; sample_out unchanged; dac_code = 0.
  - A new conversion starts from IDLE under the new mode.
- Back-to-back: after DONE and one IDLE cycle, conversion restarts automatically while adc_sel is nonzero.
- adc_sel = 0 or 3: remain IDLE; both DAC enables 0; sample_out held.
- Reset mid-conversion: immediate return to reset values, including sample_out = 0.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - An accumulator of width DATA_WIDTH+AVG_LOG2 sums 2^AVG_LOG2 consecutive results.
  - sample_out = sum >> AVG_LOG2 (truncating); sample_valid pulses once per group.
  - Accumulator and group counter clear on abort or mode change.
- Undefined: every conversion result is output directly; no accumulator logic.

Decomposition:
- Package adc_pkg:
  - enum conv_state_t {IDLE, SETTLE, DECIDE, DONE}.
  - Constants ADC_NONE=2'd0, ADC_PWM=2'd1, ADC_R2R=2'd2.
- Sub-module comp_synchronizer: 2-flop synchronizer with reset, instantiated once.

Test Plan (DATA_WIDTH=8, SETTLE_CYCLES=4; comparator model comp_in = (vin >= dac_code)):
- SAR, vin=0xA5, adc_sel=1, successive_approx=1 -> trial codes 0x80,0xC0,0xA0,0xB0,0xA8,0xA4,0xA6,0xA5; sample_out=0xA5; sample_valid pulse 41 cycles after IDLE exit; pwm_dac_en=1 and r2r_dac_en=0 during busy.
- Ramp, vin=0x10, adc_sel=2, successive_approx=0 -> dac_code steps 0x00..0x11; sample_out=0x10; r2r_dac_en=1 during busy.
- Ramp boundaries -> vin=0xFF gives 0xFF with no wrap to 0; comparator forced 0 gives 0x00.
- Mode change: successive_approx toggled mid-SAR after 3 trials -> no sample_valid, sample_out keeps previous 0xA5, new ramp conversion starts.
- adc_sel=0 -> busy=0, dac_code=0, both enables 0, no sample_valid over 200 cycles. reset asserted mid-conversion -> all outputs 0 next cycle.
- ADC_AVG_EN, AVG_LOG2=2, vin alternating 0x10/0x13 per conversion -> a single sample_valid per 4 conversions, sample_out=0x11.
